// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a fixed-baud serialiser.
// Frames are sent back-to-back, with no idle gap, while the FIFO holds data.
module uart_tx_buffered #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] UART_TX,
    input  logic       UART_TX_valid,
    output logic       UART_TX_ready,
    output logic       TX,
    output logic       busy
);

    localparam int unsigned DIV     = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned COUNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [COUNT_W-1:0] r_count;

    state_t             r_state;
    logic [CNT_W-1:0]   r_baud_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_tx;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_baud_done;
    logic [7:0]         w_head;

    assign w_full      = (r_count == COUNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = UART_TX_valid && !w_full;
    assign w_baud_done = (r_baud_cnt == CNT_W'(DIV - 1));
    assign w_head      = r_mem[r_rd_ptr];

    // The FSM takes the head byte when idle, or at the last stop cycle to chain frames.
    assign w_pop = !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));

    assign UART_TX_ready = !w_full;
    assign TX            = r_tx;
    assign busy          = (r_state != S_IDLE) || !w_empty;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= UART_TX;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_W'(1);
                2'b01:   r_count <= r_count - COUNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Serialiser; TX is updated on the same edge as each state/bit change.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift    <= w_head;
                        r_baud_cnt <= '0;
                        r_tx       <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= r_shift[0];
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (!w_empty) begin
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: cycle-by-cycle comparison of TX/ready/busy
// against a queue-and-frame-position reference model.
module tb_uart_tx_buffered;

    localparam int unsigned DIV   = 10;
    localparam int unsigned FRAME = 10 * DIV;
    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       vld = 1'b0;
    logic       ready;
    logic       tx;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bytes waiting, and position within the frame on the wire.
    byte unsigned q[$];
    bit           active = 1'b0;
    int           pos    = 0;
    byte unsigned cur    = 8'h00;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK           (clk),
        .RESET         (rst),
        .UART_TX       (din),
        .UART_TX_valid (vld),
        .UART_TX_ready (ready),
        .TX            (tx),
        .busy          (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int b;
        if (!active) return 1'b1;
        b = pos / DIV;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return cur[b-1];
    endfunction

    // Advance the model by one rising edge using the inputs that were applied.
    task automatic model_edge();
        bit acc;
        acc = vld && (q.size() < DEPTH);
        if (rst) begin
            q.delete();
            active = 1'b0;
            pos    = 0;
            return;
        end
        if (!active) begin
            if (q.size() > 0) begin
                cur    = q.pop_front();
                active = 1'b1;
                pos    = 0;
            end
        end else if (pos == FRAME - 1) begin
            if (q.size() > 0) begin
                cur = q.pop_front();
                pos = 0;
            end else begin
                active = 1'b0;
            end
        end else begin
            pos++;
        end
        if (acc) q.push_back(din);
    endtask

    task automatic check_outputs();
        check_eq("tx", 32'(tx), 32'(exp_tx()));
        check_eq("ready", 32'(ready), 32'(q.size() < DEPTH));
        check_eq("busy", 32'(busy), 32'(active || (q.size() > 0)));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 * FRAME; i++) begin
            if (!busy && !active && q.size() == 0) break;
            cycle();
        end
        check_eq(tag, 32'(busy), 32'(0));
    endtask

    initial begin
        int n_acc;
        int pct;

        // Reset pulse, then a long quiet interval.
        @(negedge clk);
        check_eq("rst_tx", 32'(tx), 32'(1));
        check_eq("rst_ready", 32'(ready), 32'(1));
        check_eq("rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        repeat (200) cycle();

        // Single bytes with known patterns.
        din = 8'h55; vld = 1'b1;
        cycle();
        vld = 1'b0;
        repeat (FRAME + 5) cycle();
        check_eq("busy_after_55", 32'(busy), 32'(0));

        din = 8'hA3; vld = 1'b1;
        cycle();
        vld = 1'b0;
        repeat (FRAME + 5) cycle();
        check_eq("busy_after_a3", 32'(busy), 32'(0));

        // Hold valid with incrementing data until the FIFO fills.
        din = 8'h00; vld = 1'b1; n_acc = 0;
        for (int i = 0; i < 100; i++) begin
            if (!ready) break;
            n_acc++;
            cycle();
            din = din + 8'd1;
        end
        check_eq("accepted_before_full", 32'(n_acc), 32'(17));

        // A byte offered while full must be dropped.
        din = 8'hEE; vld = 1'b1;
        cycle();
        vld = 1'b0;
        drain("drain_burst");

        // Randomised traffic at several offered loads.
        for (int seg = 0; seg < 6; seg++) begin
            case (seg % 4)
                0: pct = 2;
                1: pct = 10;
                2: pct = 60;
                default: pct = 100;
            endcase
            for (int i = 0; i < 500; i++) begin
                vld = ($urandom_range(0, 99) < pct);
                din = 8'($urandom);
                cycle();
            end
        end
        vld = 1'b0;
        drain("drain_random");

        // Reset mid-frame with five bytes queued; valid is held during reset.
        for (int i = 0; i < 6; i++) begin
            vld = 1'b1;
            din = 8'($urandom) & 8'hF0;
            cycle();
        end
        vld = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            if (active && pos == 44) break;
            cycle();
        end
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_tx", 32'(tx), 32'(1));
        check_eq("midrst_busy", 32'(busy), 32'(0));
        check_eq("midrst_ready", 32'(ready), 32'(1));
        vld = 1'b1; din = 8'h00;
        repeat (3) cycle();
        rst = 1'b0;
        vld = 1'b0;
        repeat (300) cycle();
        check_eq("post_rst_tx", 32'(tx), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900_000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
